id_stage: RTL and testbench

Decode stage of the 5-stage pipeline, directly downstream of the IF stage and the IF/ID register.
- Decodes the instruction from IF/ID and reads the 32x32 register file, which WB writes.
- Resolves branches and jumps in ID and returns the redirect, flush and stall controls to IF.
- Detects hazards and registers operands and control into the ID/EX pipeline register.

---
 rtl/id_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: register file, hazard/stall unit, branch resolution, ID/EX register
// Optional BRANCH_FORWARD_EN: branch compare takes MEMALUResult instead of stalling on a MEM dependency.
module id_stage #(
  parameter int REGFILE_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IFIDPCPlus4,
  input  logic [31:0] IDInstr,
  input  logic [31:0] IFPCPlus4In,
  output logic [31:0] IDJumpTarget,
  output logic [31:0] IDNonJumpTarget,
  output logic        IDJump,
  output logic        IFIDFlush,
  output logic        IFIDWrite,
  output logic        IFPCWrite,
  input  logic        WBRegWrite,
  input  logic [4:0]  WBWriteReg,
  input  logic [31:0] WBWriteData,
  input  logic        MEMRegWrite,
  input  logic [4:0]  MEMWriteReg,
  input  logic [31:0] MEMALUResult,
`ifdef BRANCH_FORWARD_EN
  input  logic        MEMMemRead,
`endif
  output logic [31:0] EXPCPlus4,
  output logic [31:0] EXReadData1,
  output logic [31:0] EXReadData2,
  output logic [31:0] EXImm,
  output logic [4:0]  EXRs,
  output logic [4:0]  EXRt,
  output logic [4:0]  EXRd,
  output logic [9:0]  EXCtrl
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [9:0]  ctrl_dec;
  logic        uses_rs, uses_rt, is_beq, is_bne, is_j;

  assign opcode   = IDInstr[31:26];
  assign rs       = IDInstr[25:21];
  assign rt       = IDInstr[20:16];
  assign rd       = IDInstr[15:11];
  assign funct    = IDInstr[5:0];
  assign imm_sext = {{16{IDInstr[15]}}, IDInstr[15:0]};

  // ctrl_dec = {ALUOp, ALUSrc, RegDst, MemToReg, MemWrite, MemRead, RegWrite}
  always_comb begin
    ctrl_dec = '0;
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          6'h20: ctrl_dec = {4'd0, 6'b010001};
          6'h22: ctrl_dec = {4'd1, 6'b010001};
          6'h24: ctrl_dec = {4'd2, 6'b010001};
          6'h25: ctrl_dec = {4'd3, 6'b010001};
          6'h2A: ctrl_dec = {4'd4, 6'b010001};
          default: ctrl_dec = '0;
        endcase
        uses_rs = (ctrl_dec != '0);
        uses_rt = (ctrl_dec != '0);
      end
      OP_LW:   begin ctrl_dec = {4'd0, 6'b101011}; uses_rs = 1'b1; end
      OP_SW:   begin ctrl_dec = {4'd0, 6'b100100}; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: begin ctrl_dec = {4'd0, 6'b100001}; uses_rs = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BNE:  begin is_bne = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: ctrl_dec = '0;
    endcase
  end

  logic [31:0][31:0] rf_q, rf_d;
  logic [31:0]       rd1, rd2, cmp_a, cmp_b;

  always_comb begin
    rf_d = rf_q;
    if (WBRegWrite && WBWriteReg != 5'd0) rf_d[WBWriteReg] = WBWriteData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (REGFILE_RESET != 0) rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // rf_d already carries the WB write, giving write-first bypass; $0 is never written
  assign rd1 = (rs == 5'd0) ? 32'd0 : rf_d[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf_d[rt];

  logic [4:0] ex_dest;
  logic       load_use, ex_hit, mem_hit, stall, rs_eq, mem_dep;

  assign ex_dest  = EXCtrl[4] ? EXRd : EXRt;
  assign load_use = EXCtrl[1] && EXRt != 5'd0 &&
                    ((uses_rs && EXRt == rs) || (uses_rt && EXRt == rt));
  assign ex_hit   = EXCtrl[0] && ex_dest != 5'd0 && (ex_dest == rs || ex_dest == rt);
  assign mem_dep  = MEMRegWrite && MEMWriteReg != 5'd0 && (MEMWriteReg == rs || MEMWriteReg == rt);

`ifdef BRANCH_FORWARD_EN
  // A MEM-stage load has only its address on MEMALUResult, so it must still stall
  assign mem_hit = mem_dep && MEMMemRead;
  assign cmp_a   = (MEMRegWrite && MEMWriteReg != 5'd0 && MEMWriteReg == rs) ? MEMALUResult : rd1;
  assign cmp_b   = (MEMRegWrite && MEMWriteReg != 5'd0 && MEMWriteReg == rt) ? MEMALUResult : rd2;
  logic unused_ok;
  assign unused_ok = ^IDInstr[10:6];
`else
  assign mem_hit = mem_dep;
  assign cmp_a   = rd1;
  assign cmp_b   = rd2;
  logic unused_ok;
  assign unused_ok = ^{MEMALUResult, IDInstr[10:6]};
`endif

  assign stall = load_use || ((is_beq || is_bne) && (ex_hit || mem_hit));
  assign rs_eq = (cmp_a == cmp_b);

  assign IDJump          = !stall && (is_j || (is_beq && rs_eq) || (is_bne && !rs_eq));
  assign IFIDFlush       = IDJump;
  assign IFIDWrite       = !stall;
  assign IFPCWrite       = !stall;
  assign IDNonJumpTarget = IFPCPlus4In;
  assign IDJumpTarget    = is_j ? {IFIDPCPlus4[31:28], IDInstr[25:0], 2'b00}
                                : IFIDPCPlus4 + {imm_sext[29:0], 2'b00};

  logic [31:0] ex_pc_q, ex_pc_d, ex_rd1_q, ex_rd1_d, ex_rd2_q, ex_rd2_d, ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [9:0]  ex_ctrl_q, ex_ctrl_d;

  always_comb begin
    ex_pc_d   = IFIDPCPlus4;
    ex_rd1_d  = rd1;
    ex_rd2_d  = rd2;
    ex_imm_d  = imm_sext;
    ex_rs_d   = rs;
    ex_rt_d   = rt;
    ex_rd_d   = rd;
    ex_ctrl_d = stall ? 10'd0 : ctrl_dec;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_pc_q   <= '0;
      ex_rd1_q  <= '0;
      ex_rd2_q  <= '0;
      ex_imm_q  <= '0;
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_rd_q   <= '0;
      ex_ctrl_q <= '0;
    end else begin
      ex_pc_q   <= ex_pc_d;
      ex_rd1_q  <= ex_rd1_d;
      ex_rd2_q  <= ex_rd2_d;
      ex_imm_q  <= ex_imm_d;
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      ex_rd_q   <= ex_rd_d;
      ex_ctrl_q <= ex_ctrl_d;
    end
  end

  assign EXPCPlus4   = ex_pc_q;
  assign EXReadData1 = ex_rd1_q;
  assign EXReadData2 = ex_rd2_q;
  assign EXImm       = ex_imm_q;
  assign EXRs        = ex_rs_q;
  assign EXRt        = ex_rt_q;
  assign EXRd        = ex_rd_q;
  assign EXCtrl      = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IFIDPCPlus4, IDInstr, IFPCPlus4In;
  logic [31:0] IDJumpTarget, IDNonJumpTarget;
  logic        IDJump, IFIDFlush, IFIDWrite, IFPCWrite;
  logic        WBRegWrite;
  logic [4:0]  WBWriteReg;
  logic [31:0] WBWriteData;
  logic        MEMRegWrite;
  logic [4:0]  MEMWriteReg;
  logic [31:0] MEMALUResult;
  logic        MEMMemRead;
  logic [31:0] EXPCPlus4, EXReadData1, EXReadData2, EXImm;
  logic [4:0]  EXRs, EXRt, EXRd;
  logic [9:0]  EXCtrl;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  id_stage dut (
    .clock(clock), .reset(reset),
    .IFIDPCPlus4(IFIDPCPlus4), .IDInstr(IDInstr), .IFPCPlus4In(IFPCPlus4In),
    .IDJumpTarget(IDJumpTarget), .IDNonJumpTarget(IDNonJumpTarget),
    .IDJump(IDJump), .IFIDFlush(IFIDFlush), .IFIDWrite(IFIDWrite), .IFPCWrite(IFPCWrite),
    .WBRegWrite(WBRegWrite), .WBWriteReg(WBWriteReg), .WBWriteData(WBWriteData),
    .MEMRegWrite(MEMRegWrite), .MEMWriteReg(MEMWriteReg), .MEMALUResult(MEMALUResult),
`ifdef BRANCH_FORWARD_EN
    .MEMMemRead(MEMMemRead),
`endif
    .EXPCPlus4(EXPCPlus4), .EXReadData1(EXReadData1), .EXReadData2(EXReadData2), .EXImm(EXImm),
    .EXRs(EXRs), .EXRt(EXRt), .EXRd(EXRd), .EXCtrl(EXCtrl)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    IDInstr = 32'h0; WBRegWrite = 1'b1; WBWriteReg = r; WBWriteData = v;
    tick();
    WBRegWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IDInstr = 32'h00221820; IFIDPCPlus4 = 32'h44;
    tick(); tick();
    tests++; if (EXCtrl !== 10'h000) begin fails++; $display("FAIL reset_ctrl got %h exp 000", EXCtrl); end
    tests++; if (EXPCPlus4 !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", EXPCPlus4); end
    tests++; if (EXRd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d exp 0", EXRd); end
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL reset_nostall got %b exp 1", IFIDWrite); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    IDInstr = 32'h00221820;
    tick();
    tests++; if (EXCtrl !== 10'h011) begin fails++; $display("FAIL add_ctrl got %h exp 011", EXCtrl); end
    tests++; if (EXRd !== 5'd3) begin fails++; $display("FAIL add_rd got %0d exp 3", EXRd); end
    tests++; if (EXReadData1 !== 32'h0 || EXReadData2 !== 32'h0) begin
      fails++; $display("FAIL add_data got %h %h exp 0 0", EXReadData1, EXReadData2); end
    tests++; if (EXPCPlus4 !== 32'h44) begin fails++; $display("FAIL add_pc got %h exp 44", EXPCPlus4); end
  endtask

  task automatic test_wb_bypass();
    IDInstr = 32'h20A6FFFC; WBRegWrite = 1'b1; WBWriteReg = 5'd5; WBWriteData = 32'h1234;
    tick();
    tests++; if (EXReadData1 !== 32'h1234) begin fails++; $display("FAIL bypass_rd1 got %h exp 1234", EXReadData1); end
    tests++; if (EXImm !== 32'hFFFFFFFC) begin fails++; $display("FAIL bypass_imm got %h exp fffffffc", EXImm); end
    tests++; if (EXCtrl !== 10'h021) begin fails++; $display("FAIL addi_ctrl got %h exp 021", EXCtrl); end
    WBWriteReg = 5'd0; WBWriteData = 32'hDEAD;
    IDInstr = 32'h00054820;
    tick();
    WBRegWrite = 1'b0;
    tests++; if (EXReadData1 !== 32'h0) begin fails++; $display("FAIL zero_reg got %h exp 0", EXReadData1); end
    tests++; if (EXReadData2 !== 32'h1234) begin fails++; $display("FAIL rf_stored got %h exp 1234", EXReadData2); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] instr [7];
    logic [9:0]  exp   [7];
    instr = '{32'h00221824, 32'h0022182A, 32'h00221825, 32'h00221822,
              32'h00221821, 32'hAC220008, 32'h8C270000};
    exp   = '{10'h091, 10'h111, 10'h0D1, 10'h051, 10'h000, 10'h024, 10'h02B};
    write_reg(5'd1, 32'h11);
    write_reg(5'd2, 32'h22);
    for (int i = 0; i < 7; i++) begin
      IDInstr = instr[i];
      tick();
      tests++; if (EXCtrl !== exp[i]) begin
        fails++; $display("FAIL alu_ctrl[%0d] got %h exp %h", i, EXCtrl, exp[i]); end
    end
    tests++; if (EXRt !== 5'd7) begin fails++; $display("FAIL lw_rt got %0d exp 7", EXRt); end
    IDInstr = 32'h20270001;
    #2;
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL addi_rt_nostall got %b exp 1", IFIDWrite); end
    IDInstr = 32'h8C200000;
    tick();
    IDInstr = 32'h00014022;
    #2;
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL lw_r0_nostall got %b exp 1", IFIDWrite); end
    tick();
  endtask

  task automatic test_load_use();
    write_reg(5'd7, 32'h77);
    IDInstr = 32'h8C270000;
    tick();
    IDInstr = 32'h00E14022;
    #2;
    tests++; if (IFIDWrite !== 1'b0 || IFPCWrite !== 1'b0) begin
      fails++; $display("FAIL lu_stall got %b%b exp 00", IFIDWrite, IFPCWrite); end
    tick();
    tests++; if (EXCtrl !== 10'h000) begin fails++; $display("FAIL lu_bubble got %h exp 000", EXCtrl); end
    #1;
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL lu_release got %b exp 1", IFIDWrite); end
    tick();
    tests++; if (EXCtrl !== 10'h051 || EXRd !== 5'd8) begin
      fails++; $display("FAIL lu_issue got ctrl %h rd %0d exp 051 8", EXCtrl, EXRd); end
    tests++; if (EXReadData1 !== 32'h77 || EXReadData2 !== 32'h11) begin
      fails++; $display("FAIL lu_data got %h %h exp 77 11", EXReadData1, EXReadData2); end
  endtask

  task automatic test_branch();
    IDInstr = 32'h0; tick();
    IFIDPCPlus4 = 32'h40; IDInstr = 32'h10000003;
    #2;
    tests++; if (IDJump !== 1'b1 || IFIDFlush !== 1'b1) begin
      fails++; $display("FAIL beq_taken got %b%b exp 11", IDJump, IFIDFlush); end
    tests++; if (IDJumpTarget !== 32'h4C) begin fails++; $display("FAIL beq_target got %h exp 4c", IDJumpTarget); end
    IDInstr = 32'h14000003;
    #2;
    tests++; if (IDJump !== 1'b0 || IFIDFlush !== 1'b0) begin
      fails++; $display("FAIL bne_not_taken got %b%b exp 00", IDJump, IFIDFlush); end
    IDInstr = 32'h1000FFFE;
    #2;
    tests++; if (IDJumpTarget !== 32'h38) begin fails++; $display("FAIL beq_neg_target got %h exp 38", IDJumpTarget); end
    IDInstr = 32'h14220001;
    #2;
    tests++; if (IDJump !== 1'b1 || IDJumpTarget !== 32'h44) begin
      fails++; $display("FAIL bne_taken got %b %h exp 1 44", IDJump, IDJumpTarget); end
    IDInstr = 32'h10220001;
    #2;
    tests++; if (IDJump !== 1'b0) begin fails++; $display("FAIL beq_ne got %b exp 0", IDJump); end
    WBRegWrite = 1'b1; WBWriteReg = 5'd2; WBWriteData = 32'h11;
    #2;
    tests++; if (IDJump !== 1'b1) begin fails++; $display("FAIL beq_wb_bypass got %b exp 1", IDJump); end
    tick();
    WBRegWrite = 1'b0;
    tests++; if (EXCtrl !== 10'h000) begin fails++; $display("FAIL branch_bubble got %h exp 000", EXCtrl); end
    IDInstr = 32'h00221820;
    tick();
    IDInstr = 32'h10600001;
    #2;
    tests++; if (IFIDWrite !== 1'b0 || IDJump !== 1'b0) begin
      fails++; $display("FAIL ex_branch_stall got %b%b exp 00", IFIDWrite, IDJump); end
    tick();
    tests++; if (IFIDWrite !== 1'b1 || IDJump !== 1'b1) begin
      fails++; $display("FAIL ex_branch_release got %b%b exp 11", IFIDWrite, IDJump); end
  endtask

  task automatic test_jump();
    IFIDPCPlus4 = 32'h80000010; IFPCPlus4In = 32'h12345678; IDInstr = 32'h08000025;
    #2;
    tests++; if (IDJump !== 1'b1 || IFIDFlush !== 1'b1) begin
      fails++; $display("FAIL j_taken got %b%b exp 11", IDJump, IFIDFlush); end
    tests++; if (IDJumpTarget !== 32'h80000094) begin fails++; $display("FAIL j_target got %h exp 80000094", IDJumpTarget); end
    tests++; if (IDNonJumpTarget !== 32'h12345678) begin
      fails++; $display("FAIL nonjump got %h exp 12345678", IDNonJumpTarget); end
    tick();
    tests++; if (EXCtrl !== 10'h000) begin fails++; $display("FAIL j_bubble got %h exp 000", EXCtrl); end
  endtask

  task automatic test_mem_branch();
    IDInstr = 32'h0; tick();
    IFIDPCPlus4 = 32'h100; IDInstr = 32'h10800001;
    MEMRegWrite = 1'b1; MEMWriteReg = 5'd4; MEMALUResult = 32'h0; MEMMemRead = 1'b0;
    #2;
`ifdef BRANCH_FORWARD_EN
    tests++; if (IFIDWrite !== 1'b1 || IDJump !== 1'b1) begin
      fails++; $display("FAIL mem_fwd got %b%b exp 11", IFIDWrite, IDJump); end
    MEMALUResult = 32'h5;
    #2;
    tests++; if (IDJump !== 1'b0) begin fails++; $display("FAIL mem_fwd_ne got %b exp 0", IDJump); end
    MEMMemRead = 1'b1;
    #2;
    tests++; if (IFIDWrite !== 1'b0) begin fails++; $display("FAIL mem_load_stall got %b exp 0", IFIDWrite); end
`else
    tests++; if (IFIDWrite !== 1'b0 || IDJump !== 1'b0 || IFIDFlush !== 1'b0) begin
      fails++; $display("FAIL mem_stall got %b%b%b exp 000", IFIDWrite, IDJump, IFIDFlush); end
`endif
    MEMWriteReg = 5'd0;
    #2;
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL mem_r0_nostall got %b exp 1", IFIDWrite); end
    tick();
    MEMRegWrite = 1'b0; MEMMemRead = 1'b0;
    #2;
    tests++; if (IDJump !== 1'b1 || IDJumpTarget !== 32'h104) begin
      fails++; $display("FAIL mem_release got %b %h exp 1 104", IDJump, IDJumpTarget); end
  endtask

  task automatic test_reset_mid_stall();
    IDInstr = 32'h8C270000;
    tick();
    IDInstr = 32'h00E14022;
    #2;
    tests++; if (IFIDWrite !== 1'b0) begin fails++; $display("FAIL mid_stall_pre got %b exp 0", IFIDWrite); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (EXCtrl !== 10'h000 || IFIDWrite !== 1'b1) begin
      fails++; $display("FAIL mid_stall_reset got %h %b exp 000 1", EXCtrl, IFIDWrite); end
    tick();
    tests++; if (EXCtrl !== 10'h051 || EXReadData1 !== 32'h0) begin
      fails++; $display("FAIL post_reset_issue got %h %h exp 051 0", EXCtrl, EXReadData1); end
  endtask

  initial begin
    reset = 1'b1; IFIDPCPlus4 = '0; IDInstr = '0; IFPCPlus4In = '0;
    WBRegWrite = 1'b0; WBWriteReg = '0; WBWriteData = '0;
    MEMRegWrite = 1'b0; MEMWriteReg = '0; MEMALUResult = '0; MEMMemRead = 1'b0;
    test_reset();
    test_add();
    test_wb_bypass();
    test_alu_ops();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_branch();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
